// File: rtl/regfile_pkg.sv
// Shared definitions for the decode-stage register file: default widths,
// clear-sequencer state encoding and the core-wide enable/zero constants.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  localparam logic RD_EN   = 1'b1;
  localparam logic WR_EN   = 1'b1;
  localparam logic RST_ACT = 1'b1;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the multi-port register file; the core drives the master
// side, the register file implements the slave side.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) ();

  logic                     clr;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     init_busy;
  logic                     wr_conflict;

  modport master (
    output clr, we, waddr, wdata, re, raddr,
    input  rdata, init_busy, wr_conflict
  );

  modport slave (
    input  clr, we, waddr, wdata, re, raddr,
    output rdata, init_busy, wr_conflict
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry once after reset or a clr pulse,
// driving a zero write into the storage array and holding init_busy.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | array usable, user reads/writes pass, clr accepted
// ST_CLEAR | entry[cnt] zeroed each cycle, init_busy high, clr ignored
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      state     <= ST_CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            init_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // Terminate on the compare so the sweep never relies on wrap-around.
          if (cnt == LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            init_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_CLEAR;
          cnt       <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR) && (rst != RST_ACT);
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with fixed write priority (higher port wins),
// optional hardwired zero entry and a registered same-address write flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     init_busy;
  logic                     clr_we;
  logic [ADDR_W-1:0]        clr_addr;
  logic                     wr_ok;
  logic                     conflict_d;
  logic                     wr_conflict;
  logic [NUM_RD*DATA_W-1:0] rdata_c;

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clr),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = (rst != RST_ACT) && !init_busy;

  // Ports are visited in ascending order so the highest index lands last.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= DATA_W'(ZERO_WORD);
    end else if (wr_ok) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] == WR_EN && addr_live(bus.waddr[k*ADDR_W +: ADDR_W]))
          mem[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  generate
    if (NUM_WR > 1) begin : g_conflict
      assign conflict_d = wr_ok && (bus.we[0] == WR_EN) && (bus.we[1] == WR_EN) &&
                          (bus.waddr[0 +: ADDR_W] == bus.waddr[ADDR_W +: ADDR_W]);
    end else begin : g_no_conflict
      assign conflict_d = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) wr_conflict <= 1'b0;
    else                wr_conflict <= conflict_d;
  end

  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (wr_ok && bus.re[i] == RD_EN && addr_live(bus.raddr[i*ADDR_W +: ADDR_W])) begin
        rdata_c[i*DATA_W +: DATA_W] = mem[bus.raddr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NUM_WR; k++) begin
          if (bus.we[k] == WR_EN &&
              bus.waddr[k*ADDR_W +: ADDR_W] == bus.raddr[i*ADDR_W +: ADDR_W])
            rdata_c[i*DATA_W +: DATA_W] = bus.wdata[k*DATA_W +: DATA_W];
        end
`endif
      end
    end
  end

  assign bus.rdata       = rdata_c;
  assign bus.init_busy   = init_busy;
  assign bus.wr_conflict = wr_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic, all compared against a behavioural array model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_busy;
  int            mdl_left;
  bit            mdl_conf;
  bit            obs_busy;
  bit            obs_conf;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int i);
    logic [AW-1:0] ra;
    ra = bus.raddr[i*AW +: AW];
    if (rst || mdl_busy || !bus.re[i] || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    for (int k = NW - 1; k >= 0; k--)
      if (bus.we[k] && bus.waddr[k*AW +: AW] == ra) return bus.wdata[k*DW +: DW];
`endif
    return mdl_mem[ra];
  endfunction

  task automatic mdl_edge();
    logic [AW-1:0] a0, a1;
    a0 = bus.waddr[0 +: AW];
    a1 = bus.waddr[AW +: AW];
    if (rst) begin
      mdl_busy = 1; mdl_left = DEPTH; mdl_conf = 0;
    end else if (mdl_busy) begin
      mdl_mem[DEPTH - mdl_left] = '0;
      mdl_left--;
      if (mdl_left == 0) mdl_busy = 0;
      mdl_conf = 0;
    end else begin
      mdl_conf = bus.we[0] && bus.we[1] && a0 == a1;
      if (bus.we[1] && a1 != 0) mdl_mem[a1] = bus.wdata[DW +: DW];
      if (bus.we[0] && a0 != 0 && !(bus.we[1] && a1 == a0)) mdl_mem[a0] = bus.wdata[0 +: DW];
      if (bus.clr) begin mdl_busy = 1; mdl_left = DEPTH; end
    end
  endtask

  task automatic step(input string tag);
    #3;
    obs_busy = bus.init_busy;
    obs_conf = bus.wr_conflict;
    check({tag, "/busy"}, {31'b0, bus.init_busy}, {31'b0, mdl_busy});
    check({tag, "/conf"}, {31'b0, bus.wr_conflict}, {31'b0, mdl_conf});
    for (int i = 0; i < NR; i++)
      check($sformatf("%s/rd%0d", tag, i), bus.rdata[i*DW +: DW], exp_rd(i));
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  task automatic idle_in();
    bus.clr = 0; bus.we = '0; bus.waddr = '0; bus.wdata = '0;
    bus.re = '0; bus.raddr = '0;
  endtask

  task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
    bus.we[k] = 1'b1;
    bus.waddr[k*AW +: AW] = AW'(a);
    bus.wdata[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    bus.re[i] = 1'b1;
    bus.raddr[i*AW +: AW] = AW'(a);
  endtask

  task automatic wait_clear(input string tag, output int nb);
    nb = 0;
    for (int n = 0; n < 40; n++) begin
      step(tag);
      if (!obs_busy) break;
      nb++;
    end
  endtask

  int nb;

  initial begin
    idle_in();
    rst = 1;
    for (int j = 0; j < DEPTH; j++) mdl_mem[j] = '0;
    @(posedge clk); #1;
    mdl_busy = 1; mdl_left = DEPTH; mdl_conf = 0;
    step("rst");
    rst = 0;
    set_rd(0, 5); set_rd(1, 5);
    wait_clear("clr0", nb);
    check("clr0_len", DW'(nb), 32);

    // reset clears a live entry
    idle_in(); set_wr(0, 5, 32'hDEADBEEF); step("pre5");
    idle_in(); set_rd(0, 5); set_rd(1, 5); step("rd5");
    rst = 1; step("rstp");
    rst = 0;
    wait_clear("clr1", nb);
    check("clr1_len", DW'(nb), 32);
    step("rd5z");
    check("rd5_zero", bus.rdata[0 +: DW], 32'h0);

    // hardwired zero entry
    idle_in(); set_wr(0, 0, 32'h12345678); step("wr0");
    idle_in(); set_rd(0, 0); set_rd(1, 0); step("rd0");

    // same-address dual write
    idle_in(); set_wr(0, 7, 32'h11111111); set_wr(1, 7, 32'h22222222); step("conf_wr");
    idle_in(); set_rd(0, 7); set_rd(1, 7);
    #3;
    check("conf_flag", {31'b0, bus.wr_conflict}, 32'h1);
    check("conf_data", bus.rdata[DW +: DW], 32'h22222222);
    #(-3 + 3); step("conf_rd");
    step("conf_clr");

    // write/read same cycle
    idle_in(); set_wr(0, 3, 32'h01010101); step("byp_pre");
    idle_in(); set_wr(0, 3, 32'hCAFEF00D); set_rd(0, 3); set_rd(1, 3); step("byp");
    idle_in(); set_rd(0, 3); set_rd(1, 3); step("byp_nxt");

    // read enable gating
    idle_in(); set_wr(1, 9, 32'h5A5A5A5A); step("re_wr");
    idle_in(); bus.raddr[0 +: AW] = 9; bus.raddr[AW +: AW] = 9; step("re_off");
    idle_in(); set_rd(0, 9); step("re_on");

    // clr pulse, write during the sweep is dropped
    idle_in(); bus.clr = 1; step("clrp");
    idle_in(); step("clr_c1");
    set_wr(0, 9, 32'hAAAA5555); step("clr_c2");
    idle_in(); set_rd(0, 9); set_rd(1, 9);
    wait_clear("clr2", nb);
    check("clr2_len", DW'(nb), 30);
    step("rd9");

    // random traffic
    for (int c = 0; c < 500; c++) begin
      idle_in();
      rst = ($urandom_range(0, 149) == 0);
      bus.clr = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < NW; k++)
        if ($urandom_range(0, 2) != 0)
          set_wr(k, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1), $urandom);
      for (int i = 0; i < NR; i++) begin
        bus.raddr[i*AW +: AW] = AW'($urandom_range(0, 7));
        bus.re[i] = ($urandom_range(0, 3) != 0);
      end
      step("rnd");
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the core's decode stage, generalising the single-write, dual-read MIPS register file. It provides NUM_RD read ports and NUM_WR write ports with fixed write-port priority and an optional hardwired-zero register. A built-in clear sequencer zeroes every entry after reset or on request, and a registered conflict flag reports same-address writes. Write-to-read forwarding is a compile-time option.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 2, number of write ports (1..2); a higher index has higher priority
- ZERO_REG, 1, when 1, entry 0 always reads zero and ignores writes
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  one-cycle pulse; restarts the clear sequence
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, packed the same way
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses, packed
- rdata  out  NUM_RD*DATA_W  read data, combinational, packed
- init_busy  out  1  high while the clear sequence runs
- wr_conflict  out  1  registered; high for one cycle after two ports wrote the same address

## Operation
- Clear sequencer states: IDLE and CLEAR.
  - rst=1: the state goes to CLEAR, cnt goes to 0, init_busy=1, wr_conflict=0.
  - In CLEAR with rst=0: entry[cnt] is written with 0 each cycle and cnt increments.
  - When cnt==DEPTH-1, the state goes to IDLE.
  - clr=1 while in IDLE: the state goes to CLEAR and cnt goes to 0. clr while in CLEAR is ignored.
- Writes:
  - Writes are accepted only in IDLE with rst=0. User writes in CLEAR or during rst are dropped.
  - Port k writes entry[waddr_k] <= wdata_k when we_k=1.
  - When ZERO_REG=1, a write to address 0 is dropped.
  - If both ports write the same address in the same cycle, port 1's data is stored. wr_conflict=1 on the next cycle, even if that address is 0.
- Reads, per port i, in priority order:
  1. rst=1 or init_busy=1 → rdata_i=0.
  2. re_i=0 → rdata_i=0.
  3. ZERO_REG=1 and raddr_i==0 → rdata_i=0.
  4. Otherwise → rdata_i = entry[raddr_i], or forwarded data when the bypass option is compiled in (see Configuration).
- Width rules: entries are DATA_W bits and no arithmetic is performed on data. cnt is ADDR_W bits; the clear ends by the cnt==DEPTH-1 compare, not by wrap-around.

## Timing
- Reset values: init_busy=1, wr_conflict=0, rdata=0 on all ports, internal cnt=0.
- Clear duration: init_busy stays high for exactly DEPTH rising edges with rst=0 after rst falls or after a clr is accepted.
  - For DEPTH=32, init_busy falls after edge 32. Writes are accepted starting at that cycle's next edge.
- rst asserted mid-clear: the sequence restarts from cnt=0. Entries already cleared remain zero.
- Write latency: data is visible on a read one cycle after the write edge, or in the same cycle with bypass.
- Read latency: zero cycles (combinational).
- wr_conflict latency: one cycle after the conflicting write. It clears on the next edge unless the conflict repeats.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Read port i returns wdata of the highest-priority port k with we_k=1, waddr_k==raddr_i, in IDLE with rst=0.
  - Precedence: the zero-register rule and the rst/init_busy/re=0 rules still take precedence.
- REGFILE_BYPASS_EN undefined:
  - Reads return stored contents only.
  - A same-cycle write becomes visible on the next cycle.

## Structure
- Shared package regfile_pkg holds:
  - default widths (DATA_W=32, ADDR_W=5);
  - the clear-sequencer state encoding (IDLE/CLEAR);
  - the read/write/reset enable-level constants and the zero-word constant, as used elsewhere in the core.
- One sub-module, regfile_clr_seq, contains the state register, cnt, and init_busy. It outputs clr_we and clr_addr to the storage array.
- Storage, write-priority muxing, read muxing, and the bypass logic stay in regfile_mp.

## Test plan
- Reset/clear: preload entry 5 with 0xDEADBEEF, pulse rst one cycle, then hold re=1, raddr=5. Required: init_busy=1 for 32 cycles, then rdata=0 on all ports.
- Zero register: after the clear completes, write 0x12345678 to address 0. Required: address 0 reads 0x00000000 on both ports.
- Dual-write conflict: port 0 writes 0x11111111 and port 1 writes 0x22222222, both to address 7, same cycle. Required: wr_conflict=1 on the next cycle, and address 7 reads 0x22222222.
- Bypass:
  - Setup: write 0xCAFEF00D to address 3 while reading address 3 in the same cycle.
  - With REGFILE_BYPASS_EN: rdata=0xCAFEF00D in that cycle.
  - Without REGFILE_BYPASS_EN: rdata is the old value that cycle and 0xCAFEF00D on the next cycle.
- Mid-operation clr: pulse clr, then attempt a write of 0xAAAA5555 to address 9 on cycle 2 of the clear. Required: the write is dropped and address 9 reads 0 after init_busy falls.
- Read enable gating: re=0 with raddr=9 holding 0x5A5A5A5A. Required: rdata=0.
